jt49_frame_player: RTL and testbench

//  Streams PSG register frames (regs 0..13) into jt49 on a frame tick (e.g. 50 Hz VBL) while sharing its register bus with the CPU.
//  - Sits between the CPU bus, a byte stream source (SD/DMA dump player) and the jt49 addr/din/cs_n/wr_n inputs.
//  - CPU always has priority; the player stalls and never interleaves inside a CPU access.

---
 rtl/jt49_frame_player_if.sv | 31 +++
 rtl/jt49_frame_player.sv | 150 +++++++++++++++
 tb/tb_jt49_frame_player.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt49_frame_player_if.sv
// Register-bus bundle around jt49_frame_player: stream bytes in, CPU bus in, jt49 bus out.
// Latency: wiring only, no logic.
// Backpressure: s_valid/s_ready handshake on the stream; the CPU and PSG sides have no flow control.
// Ports (signals):
//   s_data/s_valid/s_ready                  byte stream from the dump player
//   cpu_cs_n/cpu_wr_n/cpu_addr/cpu_din      CPU register bus (active-low strobes)
//   psg_cs_n/psg_wr_n/psg_addr/psg_din      towards the jt49 register inputs
// Modports: slave = frame player side, master = stream source / CPU / jt49 side.
interface jt49_frame_player_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       cpu_cs_n;
    logic       cpu_wr_n;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_din;
    logic       psg_cs_n;
    logic       psg_wr_n;
    logic [3:0] psg_addr;
    logic [7:0] psg_din;

    modport slave (
        input  s_data, s_valid, cpu_cs_n, cpu_wr_n, cpu_addr, cpu_din,
        output s_ready, psg_cs_n, psg_wr_n, psg_addr, psg_din
    );

    modport master (
        output s_data, s_valid, cpu_cs_n, cpu_wr_n, cpu_addr, cpu_din,
        input  s_ready, psg_cs_n, psg_wr_n, psg_addr, psg_din
    );
endinterface

// File: rtl/jt49_frame_player.sv
// Buffers one PSG register frame from a byte stream and writes it into jt49 on each frame tick.
// Latency: tick -> first wr_n low one cycle later; a frame takes 2*NREGS cycles when uncontended.
// Backpressure: s_ready high only while loading; the CPU always owns the bus, and the player waits for it.
// Ports:
//   clk, rst (sync, active-high), enable (low aborts to IDLE), tick (frame strobe)
//   bus (slave modport): stream in, CPU bus in, registered jt49 bus out
//   busy (writing a frame), frame_done (one-cycle pulse), miss_cnt (saturating missed ticks)
// Option: define JT49_FP_R13SKIP_EN to suppress the reg 13 strobe when its buffered byte is 8'hFF,
//   so the envelope is not restarted; the frame timing does not change.
module jt49_frame_player #(
    parameter int NREGS = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 tick,
    jt49_frame_player_if.slave   bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic [7:0]           miss_cnt
);

    localparam logic [3:0] LAST = 4'(NREGS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, ARMED, WR_STB, WR_GAP} state_t;

    state_t     state, state_nxt;
    logic [3:0] idx, idx_nxt;
    logic [7:0] frame_buf [NREGS];
    logic       cs_n_q;
    logic       bus_free;
    logic       buf_we;
    logic       miss;
    logic       done_nxt;
    logic       strobe;
    logic       skip;

    // One idle guard cycle after every CPU access before the player may strobe.
    assign bus_free = bus.cpu_cs_n & cs_n_q;
    assign strobe   = (state == WR_STB) & enable & bus_free;

`ifdef JT49_FP_R13SKIP_EN
    assign skip = (idx == 4'd13) && (frame_buf[idx] == 8'hFF);
`else
    assign skip = 1'b0;
`endif

    assign bus.s_ready = (state == LOAD);
    assign busy        = (state == WR_STB) || (state == WR_GAP);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        buf_we    = 1'b0;
        miss      = 1'b0;
        done_nxt  = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = LOAD;
                    idx_nxt   = '0;
                end
                LOAD: begin
                    // A tick here cannot start a frame, even with the final byte.
                    miss = tick;
                    if (bus.s_valid) begin
                        buf_we = 1'b1;
                        if (idx == LAST) begin
                            state_nxt = ARMED;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = idx + 4'd1;
                        end
                    end
                end
                ARMED: begin
                    if (tick) state_nxt = WR_STB;
                end
                WR_STB: begin
                    miss = tick;
                    if (bus_free) state_nxt = WR_GAP;
                end
                WR_GAP: begin
                    miss = tick;
                    if (idx == LAST) begin
                        state_nxt = LOAD;
                        idx_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = WR_STB;
                        idx_nxt   = idx + 4'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            cs_n_q       <= 1'b1;
            frame_done   <= 1'b0;
            miss_cnt     <= '0;
            bus.psg_cs_n <= 1'b1;
            bus.psg_wr_n <= 1'b1;
            bus.psg_addr <= '0;
            bus.psg_din  <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cs_n_q     <= bus.cpu_cs_n;
            frame_done <= done_nxt;
            if (miss && (miss_cnt != 8'hFF)) begin
                miss_cnt <= miss_cnt + 8'd1;
            end
            if (!bus.cpu_cs_n) begin
                // CPU mirror: reads pass through too, so jt49 sees the CPU cycle unchanged.
                bus.psg_cs_n <= 1'b0;
                bus.psg_wr_n <= bus.cpu_wr_n;
                bus.psg_addr <= bus.cpu_addr;
                bus.psg_din  <= bus.cpu_din;
            end else if (strobe && !skip) begin
                bus.psg_cs_n <= 1'b0;
                bus.psg_wr_n <= 1'b0;
                bus.psg_addr <= idx;
                bus.psg_din  <= frame_buf[idx];
            end else begin
                // Deassert between writes so jt49 sees a fresh wr edge per register.
                bus.psg_cs_n <= 1'b1;
                bus.psg_wr_n <= 1'b1;
            end
        end
    end

    // Frame buffer carries no reset; stale contents are always overwritten before replay.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            frame_buf[idx] <= bus.s_data;
        end
    end

endmodule

// File: tb/tb_jt49_frame_player.sv
`timescale 1ns/1ps
module tb_jt49_frame_player;

    localparam int NREGS = 14;
`ifdef JT49_FP_R13SKIP_EN
    localparam bit SKIP13 = 1'b1;
`else
    localparam bit SKIP13 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       tick;
    logic       busy;
    logic       frame_done;
    logic [7:0] miss_cnt;

    jt49_frame_player_if bus();

    jt49_frame_player #(.NREGS(NREGS)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .tick       (tick),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         exp_miss = 0;
    logic [7:0] frame_bytes [16];
    logic [3:0] cpu_a;
    logic [7:0] cpu_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bump(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // All tasks start and end at a falling edge; inputs change there and outputs are sampled there.
    task automatic load_frame(input int n, input bit tick_last);
        int waitc = 0;
        while (!bus.s_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("load_ready", 32'(bus.s_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(0, 2);
            repeat (gap) begin
                bus.s_valid = 1'b0;
                bus.s_data  = 8'($urandom);
                @(negedge clk);
            end
            bus.s_valid = 1'b1;
            bus.s_data  = frame_bytes[i];
            tick        = tick_last && (i == n - 1);
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        if (tick) begin
            tick     = 1'b0;
            exp_miss = bump(exp_miss);
        end
        if (n == NREGS) begin
            check("armed_s_ready", 32'(bus.s_ready), 32'd0);
            check("armed_miss", 32'(miss_cnt), 32'(exp_miss));
        end
    endtask

    // Plays the armed frame from a tick and compares the jt49 write sequence to the model.
    task automatic run_frame(input int cpu_idx, input int cpu_len, input int mid_tick_c,
                             input int abort_c, input int rst_c);
        logic [11:0] exp_q[$];
        logic [11:0] got_q[$];
        int  exp_done_c;
        int  done_c = -1;
        int  done_n = 0;
        int  maxc;
        int  cut_c;
        int  nmin;
        bit  partial;

        partial = (abort_c >= 0) || (rst_c >= 0);
        cut_c   = (abort_c >= 0) ? abort_c : rst_c;
        // Register i strobes 2*i+1 cycles after the tick edge when uncontended.
        for (int i = 0; i < NREGS; i++) begin
            if (partial && (2 * i + 1 > cut_c)) break;
            if (cpu_len > 0 && i == cpu_idx) begin
                repeat (cpu_len) exp_q.push_back({cpu_a, cpu_d});
            end
            if (!(SKIP13 && i == 13 && frame_bytes[13] == 8'hFF)) begin
                exp_q.push_back({4'(i), frame_bytes[i]});
            end
        end
        exp_done_c = 2 * NREGS + ((cpu_len > 0) ? cpu_len + 1 : 0);
        maxc       = 2 * NREGS + cpu_len + 6;

        bus.cpu_wr_n = 1'b0;
        bus.cpu_addr = cpu_a;
        bus.cpu_din  = cpu_d;
        tick = 1'b1;
        for (int c = 0; c <= maxc; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (!bus.psg_cs_n && !bus.psg_wr_n) got_q.push_back({bus.psg_addr, bus.psg_din});
            if (frame_done) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (rst_c >= 0 && c == rst_c + 1) begin
                exp_miss = 0;
                check("rst_psg_cs_n", 32'(bus.psg_cs_n), 32'd1);
                check("rst_psg_wr_n", 32'(bus.psg_wr_n), 32'd1);
                check("rst_psg_addr", 32'(bus.psg_addr), 32'd0);
                check("rst_psg_din", 32'(bus.psg_din), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_s_ready", 32'(bus.s_ready), 32'd0);
                check("rst_miss", 32'(miss_cnt), 32'd0);
            end
            if (abort_c >= 0 && c == abort_c + 1) begin
                check("abort_wr_n", 32'(bus.psg_wr_n), 32'd1);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_s_ready", 32'(bus.s_ready), 32'd0);
            end
            tick = (c == mid_tick_c);
            if (tick) exp_miss = bump(exp_miss);
            bus.cpu_cs_n = !(cpu_len > 0 && c >= 2 * cpu_idx && c < 2 * cpu_idx + cpu_len);
            if (abort_c >= 0 && c >= abort_c) enable = 1'b0;
            rst = (rst_c >= 0 && c == rst_c);
        end
        tick         = 1'b0;
        rst          = 1'b0;
        bus.cpu_cs_n = 1'b1;
        bus.cpu_wr_n = 1'b1;

        check("strobe_count", 32'(got_q.size()), 32'(exp_q.size()));
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            check($sformatf("strobe%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        if (partial) begin
            check("done_count", 32'(done_n), 32'd0);
        end else begin
            check("done_count", 32'(done_n), 32'd1);
            check("done_cycle", 32'(done_c), 32'(exp_done_c));
        end
        check("frame_miss", 32'(miss_cnt), 32'(exp_miss));
    endtask

    task automatic random_bytes();
        for (int i = 0; i < 16; i++) frame_bytes[i] = 8'($urandom);
    endtask

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        tick         = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_data   = 8'h00;
        bus.cpu_cs_n = 1'b1;
        bus.cpu_wr_n = 1'b1;
        bus.cpu_addr = 4'h0;
        bus.cpu_din  = 8'h00;
        cpu_a        = 4'h0;
        cpu_d        = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_s_ready", 32'(bus.s_ready), 32'd0);
        check("reset_psg_cs_n", 32'(bus.psg_cs_n), 32'd1);
        check("reset_psg_wr_n", 32'(bus.psg_wr_n), 32'd1);
        check("reset_psg_addr", 32'(bus.psg_addr), 32'd0);
        check("reset_psg_din", 32'(bus.psg_din), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        check("reset_miss", 32'(miss_cnt), 32'd0);
        rst = 1'b0;

        // Tick while disabled (IDLE) is ignored.
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        check("idle_tick_miss", 32'(miss_cnt), 32'd0);

        // Frame of bytes 0x00..0x0D.
        enable = 1'b1;
        for (int i = 0; i < 16; i++) frame_bytes[i] = 8'(i);
        load_frame(NREGS, 1'b0);
        run_frame(-1, 0, -1, -1, -1);

        // CPU writes addr 7 <- 0x38 for 3 cycles at player idx 5; reg 13 = 0xFF.
        random_bytes();
        frame_bytes[13] = 8'hFF;
        cpu_a = 4'd7;
        cpu_d = 8'h38;
        load_frame(NREGS, 1'b0);
        run_frame(5, 3, -1, -1, -1);

        // Tick with final byte is a miss; a tick mid-frame is a miss too.
        random_bytes();
        frame_bytes[13] = 8'($urandom_range(0, 254));
        cpu_a = 4'($urandom);
        cpu_d = 8'($urandom);
        load_frame(NREGS, 1'b1);
        run_frame($urandom_range(1, NREGS - 2), $urandom_range(1, 4), 7, -1, -1);

        for (int f = 0; f < 3; f++) begin
            random_bytes();
            cpu_a = 4'($urandom);
            cpu_d = 8'($urandom);
            load_frame(NREGS, 1'b0);
            run_frame($urandom_range(0, NREGS - 1), $urandom_range(0, 3), -1, -1, -1);
        end

        // Enable dropped while idx 8 is pending, then re-enabled.
        random_bytes();
        load_frame(NREGS, 1'b0);
        run_frame(-1, 0, -1, 16, -1);
        enable = 1'b1;
        @(negedge clk);
        check("reenable_s_ready", 32'(bus.s_ready), 32'd1);
        random_bytes();
        load_frame(NREGS, 1'b0);
        run_frame(-1, 0, -1, -1, -1);

        // Reset pulse while in WR_STB.
        random_bytes();
        load_frame(NREGS, 1'b0);
        run_frame(-1, 0, -1, -1, 4);

        // Ticks during a partial load: counted, no strobe, saturate at 255.
        random_bytes();
        load_frame(6, 1'b0);
        begin
            int strobes = 0;
            tick = 1'b1;
            exp_miss = bump(exp_miss);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                tick = 1'b0;
                if (!bus.psg_cs_n) strobes++;
            end
            check("load_tick_miss", 32'(miss_cnt), 32'(exp_miss));
            check("load_tick_strobes", 32'(strobes), 32'd0);
            check("load_tick_s_ready", 32'(bus.s_ready), 32'd1);
        end
        for (int t = 0; t < 300; t++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            exp_miss = bump(exp_miss);
            @(negedge clk);
        end
        check("miss_saturate", 32'(miss_cnt), 32'(exp_miss));
        check("miss_saturate_255", 32'(miss_cnt), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
